// File: rtl/hard_mem_1rw_arbiter_pkg.sv
// Shared types and sizing helpers for the two-requester 1RW memory arbiter.
package hard_mem_1rw_arbiter_pkg;

  localparam int unsigned default_width_p = 96;
  localparam int unsigned default_els_p   = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // Keeps a one-entry memory from collapsing the address to zero bits.
  function automatic int unsigned addr_width(input int unsigned els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/hard_mem_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted most recently.
module hard_mem_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic [1:0] v_i,
  output logic [1:0] yumi_o
);

  logic prio_r;  // requester that wins the next tie

  always_comb begin
    yumi_o = 2'b00;
    if (en_i) begin
      case (v_i)
        2'b01:   yumi_o = 2'b01;
        2'b10:   yumi_o = 2'b10;
        2'b11:   yumi_o = prio_r ? 2'b10 : 2'b01;
        default: yumi_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      prio_r <= 1'b0;
    else if (|yumi_o)
      prio_r <= yumi_o[0];
  end

endmodule

// File: rtl/hard_mem_1rw_arbiter.sv
// Arbitrates two requesters onto a single-port memory; optional zero-fill
// sweep after reset is enabled by defining HARD_MEM_ARB_INIT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | zero-fill sweep, one address per cycle, requests held off
// ST_RUN  | memory ready, requests arbitrated and granted combinationally
module hard_mem_1rw_arbiter
  import hard_mem_1rw_arbiter_pkg::*;
#(
  parameter  int unsigned width_p       = default_width_p,
  parameter  int unsigned els_p         = default_els_p,
  localparam int unsigned addr_width_lp = addr_width(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic [1:0]                 req_v_i,
  input  logic [1:0]                 req_w_i,
  input  logic [2*addr_width_lp-1:0] req_addr_i,
  input  logic [2*width_p-1:0]       req_data_i,
  input  logic [2*width_p-1:0]       req_mask_i,
  output logic [1:0]                 req_yumi_o,

  output logic [1:0]                 resp_v_o,
  output logic [width_p-1:0]         resp_data_o,
  output logic                       init_done_o,

  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_lp-1:0]   mem_addr_o,
  output logic [width_p-1:0]         mem_data_o,
  output logic [width_p-1:0]         mem_mask_o,
  input  logic [width_p-1:0]         mem_data_i
);

  typedef struct packed {
    logic                     w;
    logic [addr_width_lp-1:0] addr;
    logic [width_p-1:0]       data;
    logic [width_p-1:0]       mask;
  } mem_req_s;

  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

`ifdef HARD_MEM_ARB_INIT_EN
  localparam arb_state_e reset_state_lp = ST_INIT;
`else
  localparam arb_state_e reset_state_lp = ST_RUN;
`endif

  arb_state_e               state_r, state_n;
  logic [addr_width_lp-1:0] sweep_cnt_r;
  logic [1:0]               resp_v_r;
  logic                     arb_en;
  logic [1:0]               yumi;
  mem_req_s                 req_s [2];
  mem_req_s                 win_s;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_s[i].w    = req_w_i[i];
      req_s[i].addr = req_addr_i[i*addr_width_lp +: addr_width_lp];
      req_s[i].data = req_data_i[i*width_p +: width_p];
      req_s[i].mask = req_mask_i[i*width_p +: width_p];
    end
  end

  assign win_s = yumi[1] ? req_s[1] : req_s[0];

  // Outputs are qualified with reset so nothing leaks out while it is held.
  assign arb_en = !reset_i && (state_r == ST_RUN);

  hard_mem_rr_arb2 u_rr_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (arb_en),
    .v_i     (req_v_i),
    .yumi_o  (yumi)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_r <= reset_state_lp;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    if (state_r == ST_INIT && sweep_cnt_r == last_addr_lp)
      state_n = ST_RUN;
  end

  always_comb begin
    req_yumi_o  = yumi;
    init_done_o = arb_en;
    mem_v_o     = 1'b0;
    mem_w_o     = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_mask_o  = '0;
    if (!reset_i) begin
      case (state_r)
        ST_INIT: begin
`ifdef HARD_MEM_ARB_INIT_EN
          mem_v_o    = 1'b1;
          mem_w_o    = 1'b1;
          mem_addr_o = sweep_cnt_r;
          mem_data_o = '0;
          mem_mask_o = '1;
`endif
        end
        ST_RUN: begin
          if (|yumi) begin
            mem_v_o    = 1'b1;
            mem_w_o    = win_s.w;
            mem_addr_o = win_s.addr;
            mem_data_o = win_s.data;
            mem_mask_o = win_s.mask;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      sweep_cnt_r <= '0;
    else if (state_r == ST_INIT)
      sweep_cnt_r <= sweep_cnt_r + 1'b1;
  end

  // Read data comes straight from the macro; only the valid is registered.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      resp_v_r <= 2'b00;
    else
      resp_v_r <= yumi & {2{~win_s.w}};
  end

  assign resp_v_o    = resp_v_r & {2{~reset_i}};
  assign resp_data_o = mem_data_i;

endmodule
